// File: rtl/fft_pkg.sv
// Shared types for the 4-point FFT/IFFT stream blocks: default sample width,
// pipeline state encoding and a packed complex sample.
package fft_pkg;

    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ST1     = 2'd1,
        ST2     = 2'd2,
        EMIT    = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] re;
        logic signed [DEF_DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/ifft_bfly2.sv
// Combinational radix-2 butterfly: s = a + b, d = a - b, optionally d multiplied by j.
// Outputs grow by one bit so no overflow is possible.
module ifft_bfly2 #(
    parameter int W     = 16,
    parameter bit ROT_J = 1'b0
) (
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    output logic signed [W:0]   s_re,
    output logic signed [W:0]   s_im,
    output logic signed [W:0]   d_re,
    output logic signed [W:0]   d_im
);

    logic signed [W:0] ax_re, ax_im, bx_re, bx_im;
    logic signed [W:0] dr, di;

    assign ax_re = {a_re[W-1], a_re};
    assign ax_im = {a_im[W-1], a_im};
    assign bx_re = {b_re[W-1], b_re};
    assign bx_im = {b_im[W-1], b_im};

    assign s_re = ax_re + bx_re;
    assign s_im = ax_im + bx_im;
    assign dr   = ax_re - bx_re;
    assign di   = ax_im - bx_im;

    // j*(r,i) = (-i,r); a W-bit difference negates safely within W+1 bits
    generate
        if (ROT_J) begin : g_rot
            assign d_re = -di;
            assign d_im = dr;
        end else begin : g_pass
            assign d_re = dr;
            assign d_im = di;
        end
    endgenerate

endmodule

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse FFT with valid/ready in and out, two-stage radix-2 pipeline.
// Define IFFT4_ROUND_EN for round-half-up 1/4 scaling; otherwise scaling truncates toward -inf.
module ifft4_stream
    import fft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sop,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     frame_err
);

    localparam logic signed [DATA_W+2:0] RND = 2;

    state_t     state;
    logic [1:0] cnt;
    logic       in_accept;
    logic [1:0] wr_idx;

    logic signed [DATA_W-1:0] x_re_p0 [4];
    logic signed [DATA_W-1:0] x_im_p0 [4];
    logic signed [DATA_W:0]   st1_re  [4];
    logic signed [DATA_W:0]   st1_im  [4];
    logic signed [DATA_W:0]   a_re_p1 [4];
    logic signed [DATA_W:0]   a_im_p1 [4];
    logic signed [DATA_W+1:0] st2_re  [4];
    logic signed [DATA_W+1:0] st2_im  [4];
    logic signed [DATA_W-1:0] y_re_p2 [4];
    logic signed [DATA_W-1:0] y_im_p2 [4];

    // 1/4 scaling; the rounding add is done one bit wider so it cannot wrap
    function automatic logic signed [DATA_W-1:0] scale(input logic signed [DATA_W+1:0] v);
        logic signed [DATA_W+2:0] t;
        t = {v[DATA_W+1], v};
`ifdef IFFT4_ROUND_EN
        t = t + RND;
`endif
        t = t >>> 2;
        return t[DATA_W-1:0];
    endfunction

    assign in_ready  = (state == COLLECT) && !reset;
    assign in_accept = in_valid && in_ready;
    assign wr_idx    = in_sop ? 2'd0 : cnt;
    assign out_valid = (state == EMIT);
    assign out_sop   = (state == EMIT) && (cnt == 2'd0);
    assign out_re    = (state == EMIT) ? y_re_p2[cnt] : '0;
    assign out_im    = (state == EMIT) ? y_im_p2[cnt] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            cnt       <= 2'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (in_accept) begin
                        if (in_sop && cnt != 2'd0) begin
                            frame_err <= 1'b1;
                            cnt       <= 2'd1;
                        end else if (cnt == 2'd3) begin
                            cnt   <= 2'd0;
                            state <= ST1;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                ST1:  state <= ST2;
                ST2:  state <= EMIT;
                EMIT: begin
                    if (out_ready) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3)
                            state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // p0: input bin buffer
    always_ff @(posedge clk) begin
        if (in_accept) begin
            x_re_p0[wr_idx] <= in_re;
            x_im_p0[wr_idx] <= in_im;
        end
    end

    ifft_bfly2 #(.W(DATA_W), .ROT_J(1'b0)) u_st1_even (
        .a_re(x_re_p0[0]), .a_im(x_im_p0[0]), .b_re(x_re_p0[2]), .b_im(x_im_p0[2]),
        .s_re(st1_re[0]),  .s_im(st1_im[0]),  .d_re(st1_re[1]),  .d_im(st1_im[1])
    );

    ifft_bfly2 #(.W(DATA_W), .ROT_J(1'b1)) u_st1_odd (
        .a_re(x_re_p0[1]), .a_im(x_im_p0[1]), .b_re(x_re_p0[3]), .b_im(x_im_p0[3]),
        .s_re(st1_re[2]),  .s_im(st1_im[2]),  .d_re(st1_re[3]),  .d_im(st1_im[3])
    );

    // p1: first butterfly stage
    always_ff @(posedge clk) begin
        if (state == ST1) begin
            a_re_p1 <= st1_re;
            a_im_p1 <= st1_im;
        end
    end

    ifft_bfly2 #(.W(DATA_W+1), .ROT_J(1'b0)) u_st2_a (
        .a_re(a_re_p1[0]), .a_im(a_im_p1[0]), .b_re(a_re_p1[2]), .b_im(a_im_p1[2]),
        .s_re(st2_re[0]),  .s_im(st2_im[0]),  .d_re(st2_re[2]),  .d_im(st2_im[2])
    );

    ifft_bfly2 #(.W(DATA_W+1), .ROT_J(1'b0)) u_st2_b (
        .a_re(a_re_p1[1]), .a_im(a_im_p1[1]), .b_re(a_re_p1[3]), .b_im(a_im_p1[3]),
        .s_re(st2_re[1]),  .s_im(st2_im[1]),  .d_re(st2_re[3]),  .d_im(st2_im[3])
    );

    // p2: second butterfly stage, scaled to output width
    always_ff @(posedge clk) begin
        if (state == ST2) begin
            for (int n = 0; n < 4; n++) begin
                y_re_p2[n] <= scale(st2_re[n]);
                y_im_p2[n] <= scale(st2_im[n]);
            end
        end
    end

endmodule

// File: tb/tb_ifft4_stream.sv
// Randomized self-checking bench for ifft4_stream against a direct 4-point IDFT model.
module tb_ifft4_stream;
    import fft_pkg::*;

    localparam int DATA_W = DEF_DATA_W;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     in_sop = 1'b0;
    logic signed [DATA_W-1:0] in_re = '0;
    logic signed [DATA_W-1:0] in_im = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic                     out_sop;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic                     frame_err;

    int    checks = 0;
    int    errors = 0;
    int    ferr_cnt = 0;
    cplx_t fx [4];
    int    ex_re [4];
    int    ex_im [4];

    ifft4_stream #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
        .out_re(out_re), .out_im(out_im), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) ferr_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int scale_ref(input int v);
`ifdef IFFT4_ROUND_EN
        return (v + 2) >>> 2;
`else
        return v >>> 2;
`endif
    endfunction

    // x[n] = 1/4 * sum_k X[k] * j^(n*k)
    function automatic void build_expected();
        logic signed [DATA_W-1:0] t;
        for (int n = 0; n < 4; n++) begin
            int sr = 0;
            int si = 0;
            for (int k = 0; k < 4; k++) begin
                int xr = int'(fx[k].re);
                int xi = int'(fx[k].im);
                case ((n * k) % 4)
                    0: begin sr += xr; si += xi; end
                    1: begin sr -= xi; si += xr; end
                    2: begin sr -= xr; si -= xi; end
                    default: begin sr += xi; si -= xr; end
                endcase
            end
            t = DATA_W'(scale_ref(sr));
            ex_re[n] = int'(t);
            t = DATA_W'(scale_ref(si));
            ex_im[n] = int'(t);
        end
    endfunction

    task automatic set_x(input int k, input int re, input int im);
        fx[k].re = DATA_W'(re);
        fx[k].im = DATA_W'(im);
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 4; k++) set_x(k, int'($urandom()), int'($urandom()));
    endtask

    task automatic send_beat(input int re, input int im, input bit sop, input int gap);
        int w = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_sop   = sop;
        in_re    = DATA_W'(re);
        in_im    = DATA_W'(im);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_frame(input int gapmax, input bit sop0);
        for (int k = 0; k < 4; k++)
            send_beat(int'(fx[k].re), int'(fx[k].im), (k == 0) ? sop0 : 1'b0,
                      int'($urandom_range(0, gapmax)));
    endtask

    task automatic wait_first(input string tag);
        int lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
    endtask

    task automatic recv_frame(input string tag, input int stall_n, input int ready_pct);
        int i = 0;
        int guard = 0;
        int stall = 0;
        while (i < 4 && guard < 300) begin
            guard++;
            if (i == 1 && stall < stall_n) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (out_valid) begin
                check($sformatf("%s_re%0d", tag, i), int'(out_re), ex_re[i]);
                check($sformatf("%s_im%0d", tag, i), int'(out_im), ex_im[i]);
                check($sformatf("%s_sop%0d", tag, i), int'(out_sop), (i == 0) ? 1 : 0);
                if (!out_ready) check({tag, "_stall_in_ready"}, int'(in_ready), 0);
                else i++;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check({tag, "_samples_taken"}, i, 4);
        check({tag, "_idle_after"}, int'(out_valid), 0);
    endtask

    task automatic run_frame(input string tag, input int gapmax, input int stall_n,
                             input int ready_pct, input bit sop0);
        build_expected();
        send_frame(gapmax, sop0);
        wait_first(tag);
        recv_frame(tag, stall_n, ready_pct);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_in_ready_rst"}, int'(in_ready), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        reset = 1'b0;
        @(negedge clk);
        check({tag, "_in_ready_after"}, int'(in_ready), 1);
    endtask

    initial begin
        int f0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sop", int'(out_sop), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_in_ready", int'(in_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        set_x(0, 4, 0); set_x(1, 0, 0); set_x(2, 0, 0); set_x(3, 0, 0);
        run_frame("dc", 0, 0, 100, 1'b1);

        set_x(0, 0, 0); set_x(1, 4, 0); set_x(2, 0, 0); set_x(3, 0, 0);
        run_frame("tone", 0, 0, 100, 1'b1);

        rand_frame();
        run_frame("bp", 0, 5, 100, 1'b1);

        f0 = ferr_cnt;
        send_beat(int'($urandom()), int'($urandom()), 1'b1, 0);
        send_beat(int'($urandom()), int'($urandom()), 1'b0, 0);
        rand_frame();
        run_frame("ferr", 0, 0, 80, 1'b1);
        check("ferr_pulses", ferr_cnt - f0, 1);

        rand_frame();
        send_frame(0, 1'b1);
        @(negedge clk);
        do_reset("rst_st2");
        rand_frame();
        run_frame("after_st2", 1, 0, 100, 1'b1);

        rand_frame();
        build_expected();
        send_frame(0, 1'b1);
        wait_first("emit_rst");
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check("emit_rst_mid", int'(out_valid), 1);
        do_reset("rst_emit");
        rand_frame();
        run_frame("after_emit", 1, 0, 100, 1'b0);

        set_x(0, 2, 0); set_x(1, 0, 0); set_x(2, 0, 0); set_x(3, 0, 0);
        run_frame("rnd_pos", 0, 0, 100, 1'b1);
        set_x(0, -2, 0);
        run_frame("rnd_neg", 0, 0, 100, 1'b1);
        for (int k = 0; k < 4; k++) set_x(k, -(1 << (DATA_W - 1)), 0);
        run_frame("fullscale", 0, 0, 100, 1'b1);
        check("fullscale_x0_model", ex_re[0], -(1 << (DATA_W - 1)));

        for (int f = 0; f < 25; f++) begin
            rand_frame();
            run_frame($sformatf("rand%0d", f), 2, 0, 70, 1'($urandom_range(0, 1)));
        end

        check("ferr_total", ferr_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
